maple_rx: RTL and testbench

Maple bus receiver for the MapleMojo FPGA. It sits behind the `maple_ports` mux and consumes the selected port's synchronous-free `in_p1`/`in_p5` line levels. It detects the start pattern, decodes the two-phase data stream into bytes and detects the end pattern. It reports bytes, frame boundaries and errors to the register file for readout over SPI.

---
 rtl/maple_pkg.sv | 27 ++
 rtl/maple_edge_sync.sv | 44 ++++
 rtl/maple_rx.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_maple_rx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// Shared types and constants for the Maple bus receiver.
package maple_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_END
  } state_t;

  typedef enum logic {
    PH_A,
    PH_B
  } phase_t;

  typedef enum logic [1:0] {
    ERR_EDGE    = 2'd0,
    ERR_START   = 2'd1,
    ERR_ALIGN   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam int unsigned START_PULSES = 4;
  localparam int unsigned BYTE_CNT_W   = 11;

endpackage

// File: rtl/maple_edge_sync.sv
// Two-flop synchronizer plus edge detector for one Maple line.
// The fall/rise pulses are registered so that level and edges line up in the
// same cycle; level is the previous-value register.
module maple_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic level,
  output logic fall,
  output logic rise
);

  logic s1_q, s2_q, prev_q;
  logic fall_q, rise_q;
  logic fall_d, rise_d;

  // Edge detection between the synced level and its previous value.
  always_comb begin
    fall_d = prev_q & ~s2_q;
    rise_d = ~prev_q & s2_q;
  end

  // Synchronizer chain and registered edge pulses; idle line is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= in_raw;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign level = prev_q;
  assign fall  = fall_q;
  assign rise  = rise_q;

endmodule

// File: rtl/maple_rx.sv
// Maple bus receiver: start-pattern detection, two-phase data decoding,
// end-pattern detection and error reporting.
// Optional feature: define MAPLE_RX_CHECKSUM_EN to build the running XOR
// check that drives checksum_ok; otherwise checksum_ok is tied low.
module maple_rx
  import maple_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned IDLE_MIN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_p1,
  input  logic                  in_p5,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  busy,
  output logic                  checksum_ok
);

  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned IDLE_W = (IDLE_MIN > 2) ? $clog2(IDLE_MIN) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MIN - 1);

  logic l1, l5, fall1, fall5, rise1, rise5;

  maple_edge_sync u_sync_p1 (
    .clk   (clk),
    .rst   (rst),
    .in_raw(in_p1),
    .level (l1),
    .fall  (fall1),
    .rise  (rise1)
  );

  maple_edge_sync u_sync_p5 (
    .clk   (clk),
    .rst   (rst),
    .in_raw(in_p5),
    .level (l5),
    .fall  (fall5),
    .rise  (rise5)
  );

  state_t                  state_q, state_d;
  phase_t                  phase_q, phase_d;
  logic [2:0]              pcnt_q, pcnt_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shreg_q, shreg_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_end_q, frame_end_d;
  logic                    err_q, err_d;
  err_code_t               err_code_q, err_code_d;
  logic [BYTE_CNT_W-1:0]   byte_count_q, byte_count_d;
  logic                    busy_q, busy_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;

  logic      any_edge;
  logic      raise;
  err_code_t raise_code;
  logic      shift_en;
  logic      shift_bit;

  // Next-state and output decode; errors and bit shifts are collected as
  // flags and applied once after the state case so every path shares them.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    pcnt_d        = pcnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    err_code_d    = err_code_q;
    byte_count_d  = byte_count_q;
    idle_cnt_d    = '0;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    err_d         = 1'b0;
    raise         = 1'b0;
    raise_code    = ERR_EDGE;
    shift_en      = 1'b0;
    shift_bit     = 1'b0;

    any_edge = fall1 | fall5 | rise1 | rise5;
    if (state_q == ST_HUNT || state_q == ST_IDLE || any_edge) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end

    if (!enable) begin
      state_d = ST_HUNT;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (l1 && l5) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d = ST_IDLE;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (fall1 && l5) begin
            state_d = ST_START;
            pcnt_d  = '0;
          end
        end
        default: begin
          if (fall1 && fall5) begin
            raise      = 1'b1;
            raise_code = ERR_EDGE;
          end else if (!any_edge && tcnt_q == TCNT_LAST) begin
            raise      = 1'b1;
            raise_code = ERR_TIMEOUT;
          end else begin
            case (state_q)
              ST_START: begin
                if (fall5 && pcnt_q != 3'd7) begin
                  pcnt_d = pcnt_q + 3'd1;
                end
                if (rise1) begin
                  if (pcnt_q == 3'(START_PULSES)) begin
                    frame_start_d = 1'b1;
                    byte_count_d  = '0;
                    state_d       = ST_DATA;
                    phase_d       = PH_A;
                    bit_cnt_d     = '0;
                  end else begin
                    raise      = 1'b1;
                    raise_code = ERR_START;
                  end
                end
              end
              ST_DATA: begin
                if (phase_q == PH_A) begin
                  if (fall1) begin
                    shift_en  = 1'b1;
                    shift_bit = l5;
                    phase_d   = PH_B;
                  end
                end else if (fall1 && !l5) begin
                  // End pattern is only legal one bit into a fresh byte.
                  if (bit_cnt_q == 3'd1) begin
                    state_d = ST_END;
                  end else begin
                    raise      = 1'b1;
                    raise_code = ERR_ALIGN;
                  end
                end else if (fall5) begin
                  shift_en  = 1'b1;
                  shift_bit = l1;
                  phase_d   = PH_A;
                end
              end
              ST_END: begin
                if (fall1 || fall5) begin
                  raise      = 1'b1;
                  raise_code = ERR_ALIGN;
                end else if (rise5 && l1) begin
                  frame_end_d = 1'b1;
                  state_d     = ST_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end

    if (shift_en) begin
      shreg_d   = {shreg_q[6:0], shift_bit};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = shreg_d;
        rx_valid_d = 1'b1;
        if (byte_count_q != '1) begin
          byte_count_d = byte_count_q + BYTE_CNT_W'(1);
        end
      end
    end

    if (raise) begin
      err_d      = 1'b1;
      err_code_d = raise_code;
      state_d    = ST_HUNT;
    end

    busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_END);
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      phase_q       <= PH_A;
      pcnt_q        <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_EDGE;
      byte_count_q  <= '0;
      busy_q        <= 1'b0;
      idle_cnt_q    <= '0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      pcnt_q        <= pcnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      byte_count_q  <= byte_count_d;
      busy_q        <= busy_d;
      idle_cnt_q    <= idle_cnt_d;
      tcnt_q        <= tcnt_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign byte_count  = byte_count_q;
  assign busy        = busy_q;

`ifdef MAPLE_RX_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       cks_ok_q, cks_ok_d;

  // Running XOR of the frame's bytes, judged when the end pattern completes.
  always_comb begin
    xor_d    = xor_q;
    cks_ok_d = cks_ok_q;
    if (frame_start_d) begin
      xor_d    = '0;
      cks_ok_d = 1'b0;
    end
    if (rx_valid_d) begin
      xor_d = xor_q ^ rx_data_d;
    end
    if (frame_end_d) begin
      cks_ok_d = (xor_q == 8'h00);
    end
  end

  // Checksum state.
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q    <= '0;
      cks_ok_q <= 1'b0;
    end else begin
      xor_q    <= xor_d;
      cks_ok_q <= cks_ok_d;
    end
  end

  assign checksum_ok = cks_ok_q;
`else
  assign checksum_ok = 1'b0;
`endif

endmodule

// File: tb/tb_maple_rx.sv
// Self-checking bench for maple_rx: drives Maple line waveforms and compares
// every output pulse against a queue of events predicted from the frames sent.
module tb_maple_rx;

  localparam int unsigned T_CYC = 4096;
  localparam int K_START = 0, K_BYTE = 1, K_END = 2, K_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        in_p1 = 1'b1;
  logic        in_p5 = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_start, frame_end, err, busy, checksum_ok;
  logic [1:0]  err_code;
  logic [10:0] byte_count;

  maple_rx #(.TIMEOUT_CYCLES(T_CYC), .IDLE_MIN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_p1      (in_p1),
    .in_p5      (in_p5),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .err        (err),
    .err_code   (err_code),
    .byte_count (byte_count),
    .busy       (busy),
    .checksum_ok(checksum_ok)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          kind;
    int          data;
    int          cnt;
    int          cks;
    int unsigned at;
  } ev_t;
  ev_t expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int exp_cks(input logic [7:0] x);
`ifdef MAPLE_RX_CHECKSUM_EN
    return (x == 8'h00) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic push(input int kind, input int data, input int cnt, input int cks, input int unsigned at);
    ev_t e;
    e.kind = kind; e.data = data; e.cnt = cnt; e.cks = cks; e.at = at;
    expq.push_back(e);
  endtask

  // Match one observed pulse against the next predicted event.
  task automatic take(input int kind);
    ev_t e;
    check("event_expected", expq.size() > 0, 1);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.at);
      case (kind)
        K_START: begin
          check("start_busy", busy, 1);
          check("start_byte_count", byte_count, 0);
          check("start_checksum_clear", checksum_ok, 0);
        end
        K_BYTE: begin
          check("rx_data", rx_data, e.data);
          check("byte_count_at_byte", byte_count, e.cnt);
        end
        K_END: begin
          check("end_byte_count", byte_count, e.cnt);
          check("end_checksum_ok", checksum_ok, e.cks);
          check("end_busy", busy, 0);
        end
        default: begin
          check("err_code", err_code, e.data);
          check("err_busy", busy, 0);
        end
      endcase
    end
  endtask

  // Compare process: every output pulse is checked against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_end) begin
        check("frame_end_vs_rx_valid", rx_valid, 0);
        check("frame_end_vs_err", err, 0);
      end
      if (frame_start) take(K_START);
      if (rx_valid)    take(K_BYTE);
      if (frame_end)   take(K_END);
      if (err)         take(K_ERR);
    end
  end

  // Line driving: each step changes the pins once, then holds 4..6 cycles.
  task automatic set_pins(input logic a, input logic b);
    in_p1 = a;
    in_p5 = b;
  endtask

  task automatic hold();
    repeat (4 + $urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic a, input logic b);
    set_pins(a, b);
    hold();
  endtask

  task automatic idle(input int n);
    set_pins(1'b1, 1'b1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pattern with n pin-5 pulses; four pulses is the legal pattern.
  task automatic send_start(input int n, input bit expect_evt);
    step(1'b0, 1'b1);
    repeat (n) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    set_pins(1'b1, 1'b1);
    if (expect_evt) begin
      if (n == 4) push(K_START, 0, 0, 0, cyc + 4);
      else        push(K_ERR, 1, 0, 0, cyc + 4);
    end
    hold();
  endtask

  // Bit b0 on pin 5 clocked by a pin-1 fall, then b1 on pin 1 clocked by a pin-5 fall.
  task automatic send_pair(input logic b0, input logic b1, input bit last,
                           input int data, input int cnt);
    step(1'b1, b0);
    step(1'b0, b0);
    step(b1, 1'b1);
    set_pins(b1, 1'b0);
    if (last) push(K_BYTE, data, cnt, 0, cyc + 4);
    hold();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_evt, input int cnt);
    for (int k = 0; k < 4; k++)
      send_pair(b[7-2*k], b[6-2*k], expect_evt && (k == 3), b, cnt);
  endtask

  task automatic send_end(input bit expect_evt, input int cnt, input int cks);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    set_pins(1'b1, 1'b1);
    if (expect_evt) push(K_END, 0, cnt, cks, cyc + 4);
    hold();
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    logic [7:0] x;
    x = 8'h00;
    send_start(4, 1'b1);
    foreach (bytes[i]) begin
      x ^= bytes[i];
      send_byte(bytes[i], 1'b1, i + 1);
    end
    send_end(1'b1, bytes.size(), exp_cks(x));
    idle(40);
  endtask

  task automatic random_frame();
    logic [7:0] q[$];
    int n;
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    send_frame(q);
  endtask

  logic [7:0] directed[$];
  int         lit_cks;

  initial begin
`ifdef MAPLE_RX_CHECKSUM_EN
    lit_cks = 1;
`else
    lit_cks = 0;
`endif
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 0);
    check("reset_byte_count", byte_count, 0);
    check("reset_err_code", err_code, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {rx_valid, frame_start, frame_end, err}, 0);
    check("reset_checksum_ok", checksum_ok, 0);
    rst = 1'b0;
    idle(40);

    // Directed frame whose last byte is the XOR of the earlier ones.
    directed = '{8'h01, 8'h20, 8'h00, 8'h21};
    send_frame(directed);
    check("directed_rx_data_held", rx_data, 8'h21);
    check("directed_byte_count", byte_count, 4);
    check("directed_checksum_ok", checksum_ok, lit_cks);

    random_frame();

    // Short start pattern, then a good frame.
    send_start(3, 1'b1);
    idle(40);
    check("start_err_code_held", err_code, 1);
    random_frame();

    // Lines frozen after three data bits.
    begin
      logic b0, b1, b2;
      b0 = 1'($urandom); b1 = 1'($urandom); b2 = 1'($urandom);
      send_start(4, 1'b1);
      send_pair(b0, b1, 1'b0, 0, 0);
      step(1'b1, b2);
      set_pins(1'b0, b2);
      push(K_ERR, 3, 0, 0, cyc + 4 + T_CYC);
      hold();
      repeat (5000) @(posedge clk);
      #1;
      idle(40);
    end
    random_frame();

    // End pattern after five bits (fifth bit 0 so pin 5 is already low).
    send_start(4, 1'b1);
    send_pair(1'($urandom), 1'($urandom), 1'b0, 0, 0);
    send_pair(1'($urandom), 1'($urandom), 1'b0, 0, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    set_pins(1'b0, 1'b0);
    push(K_ERR, 2, 0, 0, cyc + 4);
    hold();
    idle(40);

    // Reset in the middle of the second byte of frame A, then frame B.
    send_start(4, 1'b1);
    send_byte(8'($urandom), 1'b1, 1);
    send_pair(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_rx_data", rx_data, 0);
    check("midreset_byte_count", byte_count, 0);
    check("midreset_err_code", err_code, 0);
    check("midreset_busy", busy, 0);
    send_pair(1'b0, 1'b1, 1'b0, 0, 0);
    send_pair(1'b1, 1'b1, 1'b0, 0, 0);
    send_pair(1'b0, 1'b0, 1'b0, 0, 0);
    send_byte(8'($urandom), 1'b0, 0);
    send_end(1'b0, 0, 0);
    idle(40);
    directed = '{8'h5A, 8'hC3, 8'h99};
    send_frame(directed);
    check("frame_b_byte_count", byte_count, 3);

    // Both lines fall together during DATA.
    send_start(4, 1'b1);
    set_pins(1'b0, 1'b0);
    push(K_ERR, 0, 0, 0, cyc + 4);
    hold();
    idle(40);
    check("edge_err_code_held", err_code, 0);
    check("edge_back_to_hunt", busy, 0);
    random_frame();

    // Enable dropped mid-frame: abort quietly.
    send_start(4, 1'b1);
    send_byte(8'($urandom), 1'b1, 1);
    send_pair(1'b0, 1'b1, 1'b0, 0, 0);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("disable_busy", busy, 0);
    enable = 1'b1;
    send_pair(1'b1, 1'b0, 1'b0, 0, 0);
    send_pair(1'b0, 1'b0, 1'b0, 0, 0);
    send_pair(1'b1, 1'b1, 1'b0, 0, 0);
    send_end(1'b0, 0, 0);
    idle(40);

    for (int i = 0; i < 3; i++) random_frame();

    idle(20);
    check("events_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
